// File: rtl/pipe_reg_file_sb.sv
// pipe_reg_file_sb: ID-stage register file with NUM_RD read ports, WB write-through
// bypass, optional hardwired-zero R0, a per-register busy scoreboard for RAW hazard
// detection and a saturating count of stalled cycles.
module pipe_reg_file_sb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_R0   = 1,
    parameter int READ_SYNC = 0,
    parameter int STALL_CW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    input  logic [NUM_RD-1:0]        i_rd_chk,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    output logic                     o_stall,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_sb_set,
    input  logic [ADDR_W-1:0]        i_sb_addr,
    input  logic                     i_flush,
    output logic [STALL_CW-1:0]      o_stall_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]   r_regs [DEPTH];
    logic [DEPTH-1:0]    r_busy;
    logic [STALL_CW-1:0] r_stall_cnt;

    // Writes and scoreboard sets aimed at a hardwired R0 are treated as if absent.
    logic w_wr_ok;
    logic w_set_ok;
    assign w_wr_ok  = i_wr_en  && !((ZERO_R0 != 0) && (i_wr_addr == '0));
    assign w_set_ok = i_sb_set && !((ZERO_R0 != 0) && (i_sb_addr == '0));

    // Register array: WB write lands at the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
        end else if (w_wr_ok) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Read ports: R0 forcing first, then bypass from WB, then the stored value.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_hit;
            logic [DATA_W-1:0] w_val;

            assign w_addr = i_rd_addr[gi*ADDR_W +: ADDR_W];
            assign w_hit  = w_wr_ok && (i_wr_addr == w_addr);
            assign w_val  = ((ZERO_R0 != 0) && (w_addr == '0)) ? '0 :
                            w_hit ? i_wr_data : r_regs[w_addr];
            // A producer retiring this very cycle already supplies the operand.
            assign o_rd_busy[gi] = r_busy[w_addr] & ~w_hit;

            if (READ_SYNC != 0) begin : g_sync
                logic [DATA_W-1:0] r_rd;
                // Registered read: capture the resolved operand for the next cycle.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) r_rd <= '0;
                    else        r_rd <= w_val;
                end
                assign o_rd_data[gi*DATA_W +: DATA_W] = r_rd;
            end else begin : g_comb
                assign o_rd_data[gi*DATA_W +: DATA_W] = w_val;
            end
        end
    endgenerate

    // The scoreboard is read only through registered busy bits, so an issuing
    // instruction's own set cannot stall it.
    assign o_stall = |(o_rd_busy & i_rd_chk);

    // Scoreboard: flush beats set, set beats a same-address retire (later NBA wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            if (w_wr_ok)  r_busy[i_wr_addr] <= 1'b0;
            if (w_set_ok) r_busy[i_sb_addr] <= 1'b1;
        end
    end

    // Stall-cycle counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (o_stall && (r_stall_cnt != {STALL_CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_reg_file_sb.sv
// Directed bench: two instances share stimulus, one with combinational read and a
// 16-bit stall counter (u_c), one with registered read and a 2-bit counter (u_s).
module tb_pipe_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  rd_chk = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_addr = '0;
    logic        flush = 1'b0;

    logic [63:0] c_rd_data, s_rd_data;
    logic [1:0]  c_rd_busy, s_rd_busy;
    logic        c_stall, s_stall;
    logic [15:0] c_cnt;
    logic [1:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_R0(1),
                       .READ_SYNC(0), .STALL_CW(16)) u_c (
        .clk(clk), .rst_n(rst_n), .i_rd_addr(rd_addr), .i_rd_chk(rd_chk),
        .o_rd_data(c_rd_data), .o_rd_busy(c_rd_busy), .o_stall(c_stall),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_sb_set(sb_set), .i_sb_addr(sb_addr), .i_flush(flush), .o_stall_cnt(c_cnt));

    pipe_reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_R0(1),
                       .READ_SYNC(1), .STALL_CW(2)) u_s (
        .clk(clk), .rst_n(rst_n), .i_rd_addr(rd_addr), .i_rd_chk(rd_chk),
        .o_rd_data(s_rd_data), .o_rd_busy(s_rd_busy), .o_stall(s_stall),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_sb_set(sb_set), .i_sb_addr(sb_addr), .i_flush(flush), .o_stall_cnt(s_cnt));

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_addr = '0; rd_chk = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_addr = {5'd5, 5'd3};
        rst_n = 1'b0;
        #3;
        checks++; if (c_rd_data !== 64'h0) begin errors++; $display("FAIL reset_c_data: got %h want 0", c_rd_data); end
        checks++; if (s_rd_data !== 64'h0) begin errors++; $display("FAIL reset_s_data: got %h want 0", s_rd_data); end
        checks++; if ({c_rd_busy, s_rd_busy, c_stall, s_stall} !== 6'b0) begin errors++; $display("FAIL reset_busy_stall: got %b want 0", {c_rd_busy, s_rd_busy, c_stall, s_stall}); end
        checks++; if (c_cnt !== 16'd0 || s_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", c_cnt, s_cnt); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
        next_cycle();
        wr_en = 1'b0; rd_addr = {5'd5, 5'd5};
        #1;
        checks++; if (c_rd_data !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL wr_rd_c: got %h want 0x1234/0x1234", c_rd_data); end
        checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL wr_rd_stall: got %b want 0", c_stall); end
        next_cycle();
        checks++; if (s_rd_data !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL wr_rd_s: got %h want 0x1234/0x1234", s_rd_data); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAA; rd_addr = {5'd5, 5'd7};
        #1;
        checks++; if (c_rd_data !== {32'h1234, 32'hAA}) begin errors++; $display("FAIL bypass_c: got %h want 0x1234/0xaa", c_rd_data); end
        checks++; if (s_rd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL bypass_s_early: got %h want 0x1234", s_rd_data[31:0]); end
        next_cycle();
        checks++; if (s_rd_data[31:0] !== 32'hAA) begin errors++; $display("FAIL bypass_s_late: got %h want 0xaa", s_rd_data[31:0]); end
        wr_en = 1'b0;
        #1;
        checks++; if (c_rd_data[31:0] !== 32'hAA) begin errors++; $display("FAIL bypass_stored: got %h want 0xaa", c_rd_data[31:0]); end
    endtask

    task automatic test_zero_r0();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF;
        sb_set = 1'b1; sb_addr = 5'd0; rd_addr = {5'd0, 5'd0}; rd_chk = 2'b11;
        #1;
        checks++; if (c_rd_data !== 64'h0) begin errors++; $display("FAIL r0_bypass: got %h want 0", c_rd_data); end
        next_cycle();
        idle_inputs(); rd_chk = 2'b11;
        #1;
        checks++; if (c_rd_data !== 64'h0 || s_rd_data !== 64'h0) begin errors++; $display("FAIL r0_data: got %h/%h want 0/0", c_rd_data, s_rd_data); end
        checks++; if (c_rd_busy !== 2'b00 || c_stall !== 1'b0) begin errors++; $display("FAIL r0_busy: got busy=%b stall=%b want 00/0", c_rd_busy, c_stall); end
        rd_chk = 2'b00;
        next_cycle();
    endtask

    task automatic test_hazard();
        sb_set = 1'b1; sb_addr = 5'd3; rd_addr = {5'd0, 5'd3}; rd_chk = 2'b01;
        #1;
        checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL hz_self: got stall=%b want 0", c_stall); end
        next_cycle();
        sb_set = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (c_stall !== 1'b1 || c_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL hz_stall%0d: got stall=%b busy=%b want 1/1", k, c_stall, c_rd_busy[0]); end
            next_cycle();
        end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        checks++; if (c_stall !== 1'b0 || c_rd_data[31:0] !== 32'h33) begin errors++; $display("FAIL hz_retire: got stall=%b data=%h want 0/0x33", c_stall, c_rd_data[31:0]); end
        next_cycle();
        wr_en = 1'b0;
        #1;
        checks++; if (c_stall !== 1'b0 || c_rd_busy !== 2'b00) begin errors++; $display("FAIL hz_clear: got stall=%b busy=%b want 0/00", c_stall, c_rd_busy); end
        checks++; if (c_cnt !== 16'd3 || s_cnt !== 2'd3) begin errors++; $display("FAIL hz_cnt: got %0d/%0d want 3/3", c_cnt, s_cnt); end
        rd_chk = 2'b00;
    endtask

    task automatic test_flush();
        do_reset();
        sb_set = 1'b1; sb_addr = 5'd3;
        next_cycle();
        sb_addr = 5'd4;
        next_cycle();
        sb_set = 1'b0; rd_addr = {5'd4, 5'd3};
        #1;
        checks++; if (c_rd_busy !== 2'b11) begin errors++; $display("FAIL fl_pre: got busy=%b want 11", c_rd_busy); end
        flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd9;
        next_cycle();
        flush = 1'b0; sb_set = 1'b0; rd_addr = {5'd9, 5'd3};
        #1;
        checks++; if (c_rd_busy !== 2'b00) begin errors++; $display("FAIL fl_r9_r3: got busy=%b want 00", c_rd_busy); end
        rd_addr = {5'd4, 5'd4};
        #1;
        checks++; if (s_rd_busy !== 2'b00) begin errors++; $display("FAIL fl_r4: got busy=%b want 00", s_rd_busy); end
        sb_set = 1'b1; sb_addr = 5'd6; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        next_cycle();
        idle_inputs(); rd_addr = {5'd0, 5'd6};
        #1;
        checks++; if (c_rd_busy[0] !== 1'b1 || c_rd_data[31:0] !== 32'h66) begin errors++; $display("FAIL fl_set_wins: got busy=%b data=%h want 1/0x66", c_rd_busy[0], c_rd_data[31:0]); end
    endtask

    task automatic test_saturate();
        do_reset();
        sb_set = 1'b1; sb_addr = 5'd3;
        next_cycle();
        sb_set = 1'b0; rd_addr = {5'd0, 5'd3}; rd_chk = 2'b01;
        for (int k = 0; k < 6; k++) next_cycle();
        checks++; if (s_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d want 3", s_cnt); end
        checks++; if (c_cnt !== 16'd6) begin errors++; $display("FAIL sat_wide_cnt: got %0d want 6", c_cnt); end
        checks++; if (s_stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b want 1", s_stall); end
        rst_n = 1'b0;
        #1;
        checks++; if ({c_stall, s_stall, c_rd_busy, s_rd_busy} !== 6'b0 || c_cnt !== 16'd0 || s_cnt !== 2'd0) begin errors++; $display("FAIL async_rst_ctl: got stall=%b%b busy=%b%b cnt=%0d/%0d want all 0", c_stall, s_stall, c_rd_busy, s_rd_busy, c_cnt, s_cnt); end
        checks++; if (c_rd_data !== 64'h0 || s_rd_data !== 64'h0) begin errors++; $display("FAIL async_rst_data: got %h/%h want 0/0", c_rd_data, s_rd_data); end
        rst_n = 1'b1;
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_r0();
        test_hazard();
        test_flush();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
